// File: rtl/simprisc_pkg.sv
// Shared definitions for the simple RISC datapath and its control FSM.
// Contents:
//   alu_op_t     - 3-bit ALU opcode driven on alu_control
//   opcode_t     - 4-bit instruction opcodes that are not R-type
//   ctrl_state_t - control FSM states
//   field positions inside the 16-bit instruction word
//   sext6        - sign-extends a 6-bit field to 16 bits
package simprisc_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_NOT = 3'b010,
    ALU_SHL = 3'b011,
    ALU_SHR = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  // Opcodes 4'b0xxx are R-type; the ALU opcode is the low three bits.
  typedef enum logic [3:0] {
    OP_ADDI = 4'b1000,
    OP_BEQ  = 4'b1001,
    OP_HALT = 4'b1111
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } ctrl_state_t;

  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 12;
  localparam int RD_MSB      = 11;
  localparam int RD_LSB      = 9;
  localparam int RS1_MSB     = 8;
  localparam int RS1_LSB     = 6;
  localparam int RS2_MSB     = 5;
  localparam int RS2_LSB     = 3;
  localparam int IMM_MSB     = 5;
  localparam int IMM_LSB     = 0;
  // The branch offset borrows the rd field as its upper half.
  localparam int BOFF_LO_MSB = 2;
  localparam int BOFF_LO_LSB = 0;

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

endpackage

// File: rtl/insn_decode.sv
// Combinational instruction decoder.
// Ports:
//   insn        in  16  instruction word
//   alu_control out 3   ALU opcode
//   alu_src_imm out 1   operand b selects the immediate
//   imm         out 16  sign-extended immediate (ADDI only, else 0)
//   rd/rs1/rs2  out 3   register fields
//   boff        out 16  sign-extended branch offset
//   is_write    out 1   instruction writes rd
//   is_branch   out 1   BEQ
//   is_halt     out 1   HALT
//   is_illegal  out 1   undefined opcode
module insn_decode
  import simprisc_pkg::*;
(
  input  logic [15:0] insn,
  output alu_op_t     alu_control,
  output logic        alu_src_imm,
  output logic [15:0] imm,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [15:0] boff,
  output logic        is_write,
  output logic        is_branch,
  output logic        is_halt,
  output logic        is_illegal
);

  logic [3:0] op;
  logic [5:0] imm6;

  assign op   = insn[OP_MSB:OP_LSB];
  assign imm6 = insn[IMM_MSB:IMM_LSB];
  assign rd   = insn[RD_MSB:RD_LSB];
  assign rs1  = insn[RS1_MSB:RS1_LSB];
  assign rs2  = insn[RS2_MSB:RS2_LSB];
  assign boff = sext6({insn[RD_MSB:RD_LSB], insn[BOFF_LO_MSB:BOFF_LO_LSB]});

  // Opcode decode into control signals.
  always_comb begin
    alu_control = ALU_ADD;
    alu_src_imm = 1'b0;
    imm         = 16'h0000;
    is_write    = 1'b0;
    is_branch   = 1'b0;
    is_halt     = 1'b0;
    is_illegal  = 1'b0;
    casez (op)
      4'b0???: begin
        alu_control = alu_op_t'(op[2:0]);
        is_write    = 1'b1;
      end
      OP_ADDI: begin
        alu_control = ALU_ADD;
        alu_src_imm = 1'b1;
        imm         = sext6(imm6);
        is_write    = 1'b1;
      end
      OP_BEQ: begin
        alu_control = ALU_SUB;
        is_branch   = 1'b1;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
        is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control FSM for the simple RISC core:
// IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH ..., with HALT terminal.
// All outputs are registered; pc drives imem_addr directly.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               leave IDLE
//   imem_req/imem_addr  instruction fetch request and word address
//   imem_rvalid/rdata   fetch response
//   rs1_addr, rs2_addr  register-file read addresses
//   alu_control         ALU opcode
//   alu_src_imm, imm    immediate operand select and value
//   alu_zero            ALU zero flag
//   rf_we, rf_waddr     register-file write (one-cycle pulse in WB)
//   pc                  program counter
//   halted, illegal     HALT state, sticky illegal-opcode flag
module alu_ctrl_fsm
  import simprisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [2:0]  rs1_addr,
  output logic [2:0]  rs2_addr,
  output logic [2:0]  alu_control,
  output logic        alu_src_imm,
  output logic [15:0] imm,
  input  logic        alu_zero,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] pc,
  output logic        halted,
  output logic        illegal
);

  ctrl_state_t state;
  ctrl_state_t state_next;
  logic [15:0] ir;
  logic        zero_q;
  logic [15:0] pc_next;

  alu_op_t     dec_alu_control;
  logic        dec_alu_src_imm;
  logic [15:0] dec_imm;
  logic [2:0]  dec_rd;
  logic [2:0]  dec_rs1;
  logic [2:0]  dec_rs2;
  logic [15:0] dec_boff;
  logic        dec_is_write;
  logic        dec_is_branch;
  logic        dec_is_halt;
  logic        dec_is_illegal;

  // The instruction register is stable from DECODE through WB, so the
  // decoder output is valid for the whole instruction.
  insn_decode u_decode (
    .insn        (ir),
    .alu_control (dec_alu_control),
    .alu_src_imm (dec_alu_src_imm),
    .imm         (dec_imm),
    .rd          (dec_rd),
    .rs1         (dec_rs1),
    .rs2         (dec_rs2),
    .boff        (dec_boff),
    .is_write    (dec_is_write),
    .is_branch   (dec_is_branch),
    .is_halt     (dec_is_halt),
    .is_illegal  (dec_is_illegal)
  );

  assign imem_addr = pc;

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem_rvalid) begin
          state_next = S_DECODE;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_is_halt || dec_is_illegal) begin
          state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC:  state_next = S_WB;
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Sequential pc; the offset add wraps modulo 2^16 by width.
  always_comb begin
    pc_next = pc + 16'd1;
    if (dec_is_branch && zero_q) begin
      pc_next = pc + 16'd1 + dec_boff;
    end else begin
      pc_next = pc + 16'd1;
    end
  end

  // State, datapath registers and registered outputs. Outputs tied to a
  // state are computed from state_next so they line up with that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= 16'h0000;
      ir          <= 16'h0000;
      zero_q      <= 1'b0;
      rs1_addr    <= 3'd0;
      rs2_addr    <= 3'd0;
      rf_waddr    <= 3'd0;
      alu_control <= 3'd0;
      alu_src_imm <= 1'b0;
      imm         <= 16'h0000;
      rf_we       <= 1'b0;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state    <= state_next;
      imem_req <= (state_next == S_FETCH);
      halted   <= (state_next == S_HALT);
      rf_we    <= (state_next == S_WB) && dec_is_write;

      if (state == S_FETCH && imem_rvalid) begin
        ir <= imem_rdata;
      end

      if (state == S_DECODE) begin
        rs1_addr    <= dec_rs1;
        rs2_addr    <= dec_rs2;
        rf_waddr    <= dec_rd;
        alu_control <= dec_alu_control;
        alu_src_imm <= dec_alu_src_imm;
        imm         <= dec_imm;
        if (dec_is_illegal) begin
          illegal <= 1'b1;
        end
      end

      if (state == S_EXEC) begin
        zero_q <= alu_zero;
      end

      if (state == S_WB) begin
        pc <= pc_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed self-checking bench for alu_ctrl_fsm.
module tb_alu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [2:0]  rs1_addr;
  logic [2:0]  rs2_addr;
  logic [2:0]  alu_control;
  logic        alu_src_imm;
  logic [15:0] imm;
  logic        alu_zero;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] pc;
  logic        halted;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_ctrl_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .alu_control (alu_control),
    .alu_src_imm (alu_src_imm),
    .imm         (imm),
    .alu_zero    (alu_zero),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .pc          (pc),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // From FETCH: wait 'waits' cycles, then return insn; ends in DECODE.
  task automatic deliver(input logic [15:0] insn, input int waits);
    for (int i = 0; i < waits; i++) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = insn;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    alu_zero    = 1'b0;
    #3;
    chk("rst_imem_req", {15'd0, imem_req}, 16'd0);
    chk("rst_rf_we",    {15'd0, rf_we},    16'd0);
    chk("rst_halted",   {15'd0, halted},   16'd0);
    chk("rst_illegal",  {15'd0, illegal},  16'd0);
    chk("rst_pc",       pc,                16'h0000);
    chk("rst_alu_ctl",  {13'd0, alu_control}, 16'd0);
    chk("rst_imm",      imm,               16'h0000);
    chk("rst_waddr",    {13'd0, rf_waddr}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_no_req", {15'd0, imem_req}, 16'd0);

    // SUB 0x1283 with two wait cycles.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fetch_req",  {15'd0, imem_req}, 16'd1);
    chk("fetch_addr", imem_addr, 16'h0000);
    tick();
    tick();
    chk("fetch_hold", {15'd0, imem_req}, 16'd1);
    imem_rvalid = 1'b1;
    imem_rdata  = 16'h1283;
    tick();
    // A stray response outside FETCH must not disturb the instruction.
    imem_rdata  = 16'hFFFF;
    chk("dec_no_req", {15'd0, imem_req}, 16'd0);
    chk("dec_no_we",  {15'd0, rf_we},    16'd0);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    chk("sub_alu_ctl", {13'd0, alu_control}, 16'd1);
    chk("sub_rs1",     {13'd0, rs1_addr},    16'd2);
    chk("sub_src_imm", {15'd0, alu_src_imm}, 16'd0);
    chk("exec_no_we",  {15'd0, rf_we},       16'd0);
    tick();
    chk("sub_we",    {15'd0, rf_we},    16'd1);
    chk("sub_waddr", {13'd0, rf_waddr}, 16'd1);
    chk("wb_pc_old", pc, 16'h0000);
    tick();
    chk("sub_we_pulse", {15'd0, rf_we}, 16'd0);
    chk("sub_pc",       pc, 16'h0001);
    chk("refetch_req",  {15'd0, imem_req}, 16'd1);

    // ADDI 0x827F: imm6 = 0x3F -> -1.
    deliver(16'h827F, 0);
    tick();
    chk("addi_imm",     imm, 16'hFFFF);
    chk("addi_src_imm", {15'd0, alu_src_imm}, 16'd1);
    chk("addi_alu_ctl", {13'd0, alu_control}, 16'd0);
    tick();
    chk("addi_we",    {15'd0, rf_we},    16'd1);
    chk("addi_waddr", {13'd0, rf_waddr}, 16'd1);
    tick();
    chk("addi_pc", pc, 16'h0002);

    // BEQ 0x9205 (offset +13) taken: 2 + 1 + 13 = 0x10.
    deliver(16'h9205, 1);
    tick();
    alu_zero = 1'b1;
    tick();
    alu_zero = 1'b0;
    chk("beq_fwd_no_we", {15'd0, rf_we}, 16'd0);
    tick();
    chk("beq_fwd_pc", pc, 16'h0010);

    // BEQ 0x9E56 (offset -2, rs1=1, rs2=2) taken at 0x10 -> 0x0F.
    deliver(16'h9E56, 0);
    tick();
    chk("beq_alu_ctl", {13'd0, alu_control}, 16'd1);
    chk("beq_rs1",     {13'd0, rs1_addr},    16'd1);
    chk("beq_rs2",     {13'd0, rs2_addr},    16'd2);
    alu_zero = 1'b1;
    tick();
    alu_zero = 1'b0;
    chk("beq_back_no_we", {15'd0, rf_we}, 16'd0);
    tick();
    chk("beq_back_pc", pc, 16'h000F);

    // Same BEQ not taken at 0x0F -> 0x10, then at 0x10 -> 0x11.
    deliver(16'h9E56, 0);
    tick();
    tick();
    tick();
    chk("beq_nt_pc_a", pc, 16'h0010);
    deliver(16'h9E56, 0);
    tick();
    tick();
    tick();
    chk("beq_nt_pc_b", pc, 16'h0011);

    // BEQ 0x9A05 (offset -19) taken at 0x11 wraps to 0xFFFF.
    deliver(16'h9A05, 0);
    tick();
    alu_zero = 1'b1;
    tick();
    alu_zero = 1'b0;
    tick();
    chk("neg_wrap_pc", pc, 16'hFFFF);
    chk("neg_wrap_addr", imem_addr, 16'hFFFF);

    // OR 0x6650 (rd=3) at 0xFFFF: pc wraps to 0.
    deliver(16'h6650, 0);
    tick();
    chk("or_alu_ctl", {13'd0, alu_control}, 16'd6);
    tick();
    chk("or_we",    {15'd0, rf_we},    16'd1);
    chk("or_waddr", {13'd0, rf_waddr}, 16'd3);
    tick();
    chk("pc_wrap", pc, 16'h0000);

    // ADD with rd=0 is still written.
    deliver(16'h0008, 0);
    tick();
    tick();
    chk("rd0_we",    {15'd0, rf_we},    16'd1);
    chk("rd0_waddr", {13'd0, rf_waddr}, 16'd0);
    tick();
    chk("rd0_pc", pc, 16'h0001);

    // Reset in the middle of WB.
    deliver(16'h1283, 0);
    tick();
    tick();
    chk("wbrst_pre_we", {15'd0, rf_we}, 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("wbrst_we", {15'd0, rf_we}, 16'd0);
    chk("wbrst_pc", pc, 16'h0000);
    #1;
    rst_n = 1'b1;
    tick();
    chk("wbrst_idle_req", {15'd0, imem_req}, 16'd0);
    chk("wbrst_idle_pc",  pc, 16'h0000);
    tick();
    chk("wbrst_idle_req2", {15'd0, imem_req}, 16'd0);

    // Illegal 0xA000 -> HALT with illegal set; start is then ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ill_fetch_req", {15'd0, imem_req}, 16'd1);
    deliver(16'hA000, 0);
    tick();
    chk("ill_illegal", {15'd0, illegal},  16'd1);
    chk("ill_halted",  {15'd0, halted},   16'd1);
    chk("ill_no_req",  {15'd0, imem_req}, 16'd0);
    chk("ill_no_we",   {15'd0, rf_we},    16'd0);
    start       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 16'h1283;
    tick();
    tick();
    start       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    tick();
    chk("halt_stay",   {15'd0, halted},   16'd1);
    chk("halt_no_req", {15'd0, imem_req}, 16'd0);
    chk("halt_no_we",  {15'd0, rf_we},    16'd0);
    chk("halt_pc",     pc, 16'h0000);
    chk("halt_sticky", {15'd0, illegal},  16'd1);

    // Reset clears HALT; HALT opcode 0xF000 halts without illegal.
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst2_halted",  {15'd0, halted},  16'd0);
    chk("rst2_illegal", {15'd0, illegal}, 16'd0);
    #1;
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    deliver(16'hF000, 2);
    tick();
    chk("hop_halted",  {15'd0, halted},  16'd1);
    chk("hop_illegal", {15'd0, illegal}, 16'd0);
    chk("hop_no_req",  {15'd0, imem_req}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_fsm.md
ALU_CTRL_FSM -- requirements
Module: alu_ctrl_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: port clk (posedge) and port rst_n.
REQ-002 Port list, in this order (name, direction, width, meaning):
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- start  in  1  leave IDLE and begin fetching at pc
- imem_req  out  1  fetch request; held high until accepted
- imem_addr  out  16  word address (= pc)
- imem_rvalid  in  1  imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- rs1_addr  out  3  register-file read port A
- rs2_addr  out  3  register-file read port B
- alu_control  out  3  ALU opcode (000 add, 001 sub, 010 not, 011 shl, 100 shr, 101 and, 110 or, 111 slt)
- alu_src_imm  out  1  1: ALU operand b = imm, 0: operand b = rs2 data
- imm  out  16  sign-extended immediate
- alu_zero  in  1  ALU zero flag (result == 0)
- rf_we  out  1  register-file write enable, one-cycle pulse
- rf_waddr  out  3  write address
- pc  out  16  program counter
- halted  out  1  in HALT state
- illegal  out  1  sticky; undefined opcode seen

Function
REQ-003 Instruction fields: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm6=[5:0], boff6={[11:9],[2:0]}.
REQ-004 Opcodes:
- 0xxx: R-type; alu_control=op[2:0], alu_src_imm=0, write rd.
- 1000 ADDI: alu_control=000, alu_src_imm=1, imm=sext(imm6), write rd.
- 1001 BEQ: alu_control=001 on rs1/rs2, no write; taken when alu_zero=1.
- 1111 HALT.
- All others illegal.
REQ-005 States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-006 IDLE->FETCH on start=1; start is ignored in every other state.
REQ-007 FETCH: imem_req=1, imem_addr=pc; latch imem_rdata into the instruction register and go to DECODE in the cycle imem_rvalid=1. Wait indefinitely otherwise; imem_rvalid outside FETCH is ignored.
REQ-008 DECODE (1 cycle): register rs1_addr, rs2_addr, alu_control, alu_src_imm and imm.
- HALT opcode -> HALT.
- Illegal opcode -> set illegal and go to HALT.
- Otherwise -> EXEC.
REQ-009 EXEC (1 cycle): decoded outputs held stable; sample alu_zero at the end of the cycle.
REQ-010 WB (1 cycle):
- rf_we=1 with rf_waddr=rd for R-type and ADDI; rf_we=0 for BEQ.
- pc <= pc+1, or pc+1+sext(boff6) for a taken BEQ.
- Next state FETCH.
REQ-011 pc arithmetic SHALL be 16-bit modulo: 0xFFFF+1=0x0000, and negative offsets wrap.
REQ-012 Cycle latency for a non-branch instruction SHALL be (fetch wait + 1) + 3: DECODE, EXEC, WB.
REQ-013 HALT is terminal: halted=1, imem_req=0, rf_we=0; only reset leaves it.
REQ-014 rf_we SHALL never be high outside WB; imem_req SHALL never be high outside FETCH.
REQ-015 rd=0 writes are issued normally; register-0 semantics belong to the register file.

Reset
REQ-016 On rst_n low, asynchronously:
- state=IDLE, pc=0x0000, instruction register=0.
- rs1_addr, rs2_addr, rf_waddr, alu_control = 0; imm=0; alu_src_imm=0.
- rf_we=0, imem_req=0, halted=0, illegal=0.
REQ-017 Reset asserted mid-FETCH or mid-WB SHALL abort the instruction with no register write and no pc update; the first cycle after deassertion is IDLE.

Structure
REQ-018 Package simprisc_pkg SHALL hold the alu_op_t enum (3 bit), opcode_t enum (4 bit), ctrl_state_t enum and the field-position constants; the ALU and this block both import it.
REQ-019 Combinational sub-module insn_decode: instruction -> alu_control, alu_src_imm, imm, is_write, is_branch, is_halt, is_illegal. The FSM and registers stay in alu_ctrl_fsm.

Verification
REQ-020 Scenario: reset, start, imem returns 0x1283 (op 0001 sub, rd=1, rs1=2, rs2=0) with rvalid after 2 waits.
- Required: alu_control=001 in EXEC; rf_we pulse with rf_waddr=1 in WB; pc=1.
REQ-021 Scenario: ADDI 0x827F (rd=1, rs1=1, imm6=0x3F).
- Required: imm=0xFFFF, alu_src_imm=1, alu_control=000.
REQ-022 Scenario: BEQ at pc=0x0010 with boff6=0x3E (-2) and alu_zero=1.
- Required: pc=0x000F and no rf_we.
- Same instruction with alu_zero=0: pc=0x0011.
REQ-023 Scenario: pc=0xFFFF with an R-type instruction.
- Required: pc wraps to 0x0000.
REQ-024 Scenario: fetch 0xA000.
- Required: illegal=1, halted=1, no rf_we, imem_req stays 0.
- Further start pulses are ignored.
REQ-025 Scenario: rst_n asserted during WB of an R-type instruction.
- Required: rf_we=0 immediately, pc=0, state IDLE.
